// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, flush and forwarding control for the five-stage pipeline
// with a memory-wait FSM, access timeout and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             rfweE,
  input  logic             rfweM,
  input  logic             rfweW,
  input  logic             mtorfselE,
  input  logic             mtorfselM,
  input  logic             branchD,
  input  logic             pcsrcD,
  input  logic             dmreqM,
  input  logic             dmreadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic [1:0]       fwdAE,
  output logic [1:0]       fwdBE,
  output logic             fwdAD,
  output logic             fwdBD,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [7:0]       waitcnt, waitcnt_nxt;
  logic             err_set;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             depE, depM, lwstall, brstall, timeout_now, memstall, hold_fd;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic wem,
                                         input logic [4:0] wrm, input logic wew,
                                         input logic [4:0] wrw);
    if (src == 5'd0)               return 2'b00;
    else if (wem && wrm == src)    return 2'b10;
    else if (wew && wrw == src)    return 2'b01;
    else                           return 2'b00;
  endfunction

  always_comb begin
    depE        = rfweE && (writeregE != 5'd0) && (writeregE == rsD || writeregE == rtD);
    depM        = mtorfselM && (writeregM != 5'd0) && (writeregM == rsD || writeregM == rtD);
    lwstall     = mtorfselE && depE;
    brstall     = branchD && (depE || depM);
    timeout_now = (state == MEM_WAIT) && (waitcnt == WAIT_LAST);
    memstall    = dmreqM && !dmreadyM && !timeout_now;
    hold_fd     = memstall || lwstall || brstall;
  end

  // Everything observable is held at zero while reset is asserted.
  always_comb begin
    stallF       = 1'b0;
    stallD       = 1'b0;
    stallE       = 1'b0;
    stallM       = 1'b0;
    flushD       = 1'b0;
    flushE       = 1'b0;
    fwdAE        = 2'b00;
    fwdBE        = 2'b00;
    fwdAD        = 1'b0;
    fwdBD        = 1'b0;
    mem_err      = 1'b0;
    stall_cycles = '0;
    if (!rst) begin
      stallM       = memstall;
      stallE       = memstall;
      stallD       = hold_fd;
      stallF       = hold_fd;
      flushE       = (lwstall || brstall) && !memstall;
      flushD       = pcsrcD && !hold_fd;
      fwdAE        = fwd_sel(rsE, rfweM, writeregM, rfweW, writeregW);
      fwdBE        = fwd_sel(rtE, rfweM, writeregM, rfweW, writeregW);
      fwdAD        = (rsD != 5'd0) && rfweM && (writeregM == rsD);
      fwdBD        = (rtD != 5'd0) && rfweM && (writeregM == rtD);
      mem_err      = mem_err_q;
      stall_cycles = stall_cnt_q;
    end
  end

  always_comb begin
    state_nxt   = state;
    waitcnt_nxt = 8'd0;
    err_set     = 1'b0;
    case (state)
      RUN: begin
        if (dmreqM && !dmreadyM) begin
          state_nxt   = MEM_WAIT;
          waitcnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        // A withdrawn request is not an error; only a live request that never completes is.
        if (!dmreqM || dmreadyM) begin
          state_nxt = RUN;
        end else if (timeout_now) begin
          state_nxt = RUN;
          err_set   = 1'b1;
        end else begin
          waitcnt_nxt = waitcnt + 8'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      waitcnt     <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state   <= state_nxt;
      waitcnt <= waitcnt_nxt;
      if (err_set)
        mem_err_q <= 1'b1;
      if (hold_fd && stall_cnt_q != {CNT_W{1'b1}})
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks of pipe_hazard_ctrl
// against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CW    = 5;
  localparam int SAT   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic rfweE, rfweM, rfweW, mtorfselE, mtorfselM, branchD, pcsrcD, dmreqM, dmreadyM;
  logic stallF, stallD, stallE, stallM, flushD, flushE, fwdAD, fwdBD, mem_err;
  logic [1:0] fwdAE, fwdBE;
  logic [CW-1:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_wait;
  int m_cnt;
  bit m_err;
  int m_sc;
  logic [11:0] e_vec;
  bit e_stallF;
  logic [11:0] dut_vec;

  assign dut_vec = {stallF, stallD, stallE, stallM, flushD, flushE, fwdAE, fwdBE, fwdAD, fwdBD};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .rfweE(rfweE), .rfweM(rfweM), .rfweW(rfweW),
    .mtorfselE(mtorfselE), .mtorfselM(mtorfselM),
    .branchD(branchD), .pcsrcD(pcsrcD), .dmreqM(dmreqM), .dmreadyM(dmreadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE),
    .fwdAE(fwdAE), .fwdBE(fwdBE), .fwdAD(fwdAD), .fwdBD(fwdBD),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (rfweM && writeregM == src) return 2'b10;
    if (rfweW && writeregW == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_comb();
    bit depE, depM, lw, br, tmo, mem, hz;
    depE = rfweE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
    depM = mtorfselM && writeregM != 0 && (writeregM == rsD || writeregM == rtD);
    lw   = mtorfselE && depE;
    br   = branchD && (depE || depM);
    tmo  = m_wait && (m_cnt == TMO - 1);
    mem  = dmreqM && !dmreadyM && !tmo;
    hz   = mem || lw || br;
    e_stallF = rst ? 1'b0 : hz;
    if (rst)
      e_vec = '0;
    else
      e_vec = {hz, hz, mem, mem, pcsrcD && !hz, (lw || br) && !mem,
               ref_fwd(rsE), ref_fwd(rtE),
               (rsD != 0) && rfweM && writeregM == rsD,
               (rtD != 0) && rfweM && writeregM == rtD};
  endtask

  task automatic tick();
    bit tmo;
    model_comb();
    tmo = m_wait && (m_cnt == TMO - 1);
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_cnt = 0; m_err = 0; m_sc = 0;
    end else begin
      if (e_stallF && m_sc < SAT) m_sc++;
      if (!m_wait) begin
        if (dmreqM && !dmreadyM) begin m_wait = 1; m_cnt = 1; end
      end else if (!dmreqM || dmreadyM) begin
        m_wait = 0; m_cnt = 0;
      end else if (tmo) begin
        m_wait = 0; m_cnt = 0; m_err = 1;
      end else begin
        m_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {rfweE, rfweM, rfweW, mtorfselE, mtorfselM, branchD, pcsrcD, dmreqM, dmreadyM} = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    rsE = 5; rfweM = 1; writeregM = 5; dmreqM = 1;
    mtorfselE = 1; rfweE = 1; writeregE = 2; rsD = 2; pcsrcD = 1;
    #1;
    n_cmp++;
    if (dut_vec !== 12'd0 || mem_err !== 1'b0 || stall_cycles !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got vec=%b err=%b sc=%0d, need all zero", dut_vec, mem_err, stall_cycles);
    end
    tick(); tick();
    clear_inputs();
    rst = 0;
    #1;
    n_cmp++;
    if (dut_vec !== 12'd0 || mem_err !== 1'b0 || stall_cycles !== '0) begin
      n_bad++;
      $display("FAIL reset_release: got vec=%b err=%b sc=%0d, need all zero", dut_vec, mem_err, stall_cycles);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    rsE = 5; rtE = 5; rfweM = 1; writeregM = 5; rfweW = 1; writeregW = 5;
    #1;
    n_cmp++;
    if (fwdAE !== 2'b10 || fwdBE !== 2'b10) begin
      n_bad++;
      $display("FAIL fwd_m_priority: got fwdAE=%b fwdBE=%b, need 10 10", fwdAE, fwdBE);
    end
    rfweM = 0;
    #1;
    n_cmp++;
    if (fwdAE !== 2'b01 || fwdBE !== 2'b01) begin
      n_bad++;
      $display("FAIL fwd_w: got fwdAE=%b fwdBE=%b, need 01 01", fwdAE, fwdBE);
    end
    rfweM = 1; writeregM = 0; rsE = 0; rtE = 0; writeregW = 0;
    #1;
    n_cmp++;
    if (fwdAE !== 2'b00 || fwdBE !== 2'b00) begin
      n_bad++;
      $display("FAIL fwd_r0: got fwdAE=%b fwdBE=%b, need 00 00", fwdAE, fwdBE);
    end
    writeregM = 7; rsD = 7; rtD = 6;
    #1;
    n_cmp++;
    if (fwdAD !== 1'b1 || fwdBD !== 1'b0 || stallF !== 1'b0) begin
      n_bad++;
      $display("FAIL fwd_decode: got fwdAD=%b fwdBD=%b stallF=%b, need 1 0 0", fwdAD, fwdBD, stallF);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    mtorfselE = 1; rfweE = 1; writeregE = 8; rsD = 8;
    #1;
    n_cmp++;
    if (stallF !== 1 || stallD !== 1 || flushE !== 1 || stallE !== 0 || stallM !== 0 || flushD !== 0) begin
      n_bad++;
      $display("FAIL load_use: got F=%b D=%b fE=%b E=%b M=%b fD=%b, need 1 1 1 0 0 0",
               stallF, stallD, flushE, stallE, stallM, flushD);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (stall_cycles !== CW'(1) || stallF !== 0) begin
      n_bad++;
      $display("FAIL load_use_count: got sc=%0d stallF=%b, need 1 0", stall_cycles, stallF);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    branchD = 1; rsD = 3; rfweE = 1; writeregE = 3; pcsrcD = 1;
    #1;
    n_cmp++;
    if (stallD !== 1 || flushE !== 1 || flushD !== 0) begin
      n_bad++;
      $display("FAIL branch_stall: got stallD=%b flushE=%b flushD=%b, need 1 1 0", stallD, flushE, flushD);
    end
    tick();
    clear_inputs();
    branchD = 1; pcsrcD = 1; rsD = 3;
    #1;
    n_cmp++;
    if (flushD !== 1 || stallD !== 0 || flushE !== 0) begin
      n_bad++;
      $display("FAIL branch_taken: got flushD=%b stallD=%b flushE=%b, need 1 0 0", flushD, stallD, flushE);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    int stalled;
    int sc0;
    clear_inputs();
    sc0 = m_sc;
    stalled = 0;
    dmreqM = 1;
    // memory wait plus a concurrent load-use hazard: no bubble while M holds
    mtorfselE = 1; rfweE = 1; writeregE = 9; rtD = 9;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stallF && stallD && stallE && stallM && !flushE) stalled++;
      tick();
    end
    mtorfselE = 0; rfweE = 0;
    dmreadyM = 1;
    #1;
    n_cmp++;
    if (stalled !== 3 || stallF !== 0 || stallM !== 0) begin
      n_bad++;
      $display("FAIL mem_wait: got stalled=%0d release_stallF=%b stallM=%b, need 3 0 0", stalled, stallF, stallM);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (mem_err !== 0 || stallF !== 0 || stall_cycles !== CW'(sc0 + 3)) begin
      n_bad++;
      $display("FAIL mem_wait_after: got err=%b stallF=%b sc=%0d, need 0 0 %0d", mem_err, stallF, stall_cycles, sc0 + 3);
    end
  endtask

  task automatic test_timeout();
    int stalled;
    clear_inputs();
    stalled = 0;
    dmreqM = 1;
    for (int i = 0; i < 3 * TMO; i++) begin
      #1;
      if (!stallF) break;
      stalled++;
      tick();
    end
    n_cmp++;
    if (stalled !== TMO - 1 || mem_err !== 0) begin
      n_bad++;
      $display("FAIL timeout_len: got stalled=%0d err=%b, need %0d 0", stalled, mem_err, TMO - 1);
    end
    tick();
    dmreqM = 0;
    #1;
    n_cmp++;
    if (mem_err !== 1) begin
      n_bad++;
      $display("FAIL timeout_err: got mem_err=%b, need 1", mem_err);
    end
    for (int i = 0; i < 4; i++) tick();
    dmreqM = 1; dmreadyM = 1;
    tick();
    #1;
    n_cmp++;
    if (mem_err !== 1) begin
      n_bad++;
      $display("FAIL timeout_sticky: got mem_err=%b, need 1", mem_err);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    dmreqM = 1;
    tick();
    tick();
    rst = 1;
    #1;
    n_cmp++;
    if (dut_vec !== 12'd0 || mem_err !== 0 || stall_cycles !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_wait: got vec=%b err=%b sc=%0d, need all zero", dut_vec, mem_err, stall_cycles);
    end
    tick();
    rst = 0;
    dmreqM = 0;
    #1;
    n_cmp++;
    if (stallF !== 0 || stall_cycles !== '0 || mem_err !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_wait_after: got stallF=%b sc=%0d err=%b, need 0 0 0", stallF, stall_cycles, mem_err);
    end
    // a fresh wait must start from scratch, lasting the full timeout again
    dmreqM = 1;
    for (int i = 0; i < TMO - 1; i++) tick();
    #1;
    n_cmp++;
    if (stallF !== 0 || stall_cycles !== CW'(TMO - 1)) begin
      n_bad++;
      $display("FAIL rewait_timeout: got stallF=%b sc=%0d, need 0 %0d", stallF, stall_cycles, TMO - 1);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_saturation();
    clear_inputs();
    mtorfselE = 1; rfweE = 1; writeregE = 4; rsD = 4;
    for (int i = 0; i < SAT + 8; i++) tick();
    #1;
    n_cmp++;
    if (stall_cycles !== CW'(SAT) || stall_cycles !== CW'(m_sc)) begin
      n_bad++;
      $display("FAIL saturation: got sc=%0d, need %0d", stall_cycles, SAT);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      rsD       = 5'($urandom_range(0, 3));
      rtD       = 5'($urandom_range(0, 3));
      rsE       = 5'($urandom_range(0, 3));
      rtE       = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      {rfweE, rfweM, rfweW, mtorfselE, mtorfselM, branchD, pcsrcD} = 7'($urandom);
      dmreqM    = ($urandom_range(0, 3) != 0);
      dmreadyM  = ($urandom_range(0, 3) == 0);
      if (m_wait && m_cnt == TMO - 1) dmreqM = 1;
      #1;
      model_comb();
      n_cmp++;
      if (dut_vec !== e_vec) begin
        n_bad++;
        $display("FAIL rand_comb[%0d]: got %b, need %b", i, dut_vec, e_vec);
      end
      tick();
      #1;
      n_cmp++;
      if (mem_err !== (rst ? 1'b0 : m_err) || stall_cycles !== (rst ? CW'(0) : CW'(m_sc))) begin
        n_bad++;
        $display("FAIL rand_state[%0d]: got err=%b sc=%0d, need %b %0d", i, mem_err, stall_cycles,
                 rst ? 1'b0 : m_err, rst ? 0 : m_sc);
      end
    end
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
